// File: rtl/sample_framer.sv
// sample_framer: buffers 16-bit samples in a small circular FIFO and emits each
// one as a byte frame (SYNC_BYTE, sample MSB, sample LSB[, checksum]) to a UART
// transmitter, one byte per DV strobe, paced by the transmitter's Active/Done.
// Optional feature: define CHECKSUM_EN to append byte 3 = sample[15:8] ^ sample[7:0].
//
// Sample handshake: a sample is accepted on any rising edge where
// in_Sample_Valid and out_Sample_Ready are both 1; out_Sample_Ready depends only
// on registered state. in_Sample_Valid while not ready drops the sample and bumps
// the saturating out_Drop_Count.
module sample_framer #(
  parameter int          FIFO_DEPTH_LOG2 = 2,
  parameter logic [7:0]  SYNC_BYTE       = 8'hA5
) (
  input  logic        in_Clock,
  input  logic        in_Reset,
  input  logic        in_Sample_Valid,
  input  logic [15:0] in_Sample,
  output logic        out_Sample_Ready,
  output logic        out_Tx_DV,
  output logic [7:0]  out_Tx_Byte,
  input  logic        in_Tx_Active,
  input  logic        in_Tx_Done,
  output logic        out_Busy,
  output logic [7:0]  out_Drop_Count
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0] FULL_COUNT = (FIFO_DEPTH_LOG2+1)'(DEPTH);

`ifdef CHECKSUM_EN
  localparam logic [1:0] LAST_IDX = 2'd3;
`else
  localparam logic [1:0] LAST_IDX = 2'd2;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  // FSM state is kept as a named signal so checkers can bind to it directly.
  state_t state;
  state_t state_next;

  logic [15:0]                mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   count;
  logic                       wr_en;
  logic                       pop;

  logic [15:0] frame;
  logic [1:0]  byte_idx;
  logic [1:0]  send_idx;
  logic [7:0]  send_byte;
  logic        tx_dv_d;
  logic [7:0]  tx_byte_d;

  logic        done_q;
  logic        done_rise;

  assign out_Sample_Ready = (count != FULL_COUNT);
  assign wr_en            = in_Sample_Valid & out_Sample_Ready;
  assign pop              = (state == ST_IDLE) && (state_next == ST_LOAD);
  assign done_rise        = in_Tx_Done & ~done_q;
  assign out_Busy         = (state != ST_IDLE);

  // Sample storage; contents need no reset because count gates every read.
  always_ff @(posedge in_Clock) begin
    if (wr_en) mem[wr_ptr] <= in_Sample;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the depth.
  always_ff @(posedge in_Clock) begin
    if (in_Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !pop)      count <= count + 1'b1;
      else if (!wr_en && pop) count <= count - 1'b1;
    end
  end

  // Saturating counter of samples offered while the FIFO was full.
  always_ff @(posedge in_Clock) begin
    if (in_Reset) begin
      out_Drop_Count <= 8'd0;
    end else if (in_Sample_Valid && !out_Sample_Ready && out_Drop_Count != 8'hFF) begin
      out_Drop_Count <= out_Drop_Count + 8'd1;
    end
  end

  // Delayed Done so that only its rising edge completes a byte.
  always_ff @(posedge in_Clock) begin
    if (in_Reset) done_q <= 1'b0;
    else          done_q <= in_Tx_Done;
  end

  // FSM state register.
  always_ff @(posedge in_Clock) begin
    if (in_Reset) state <= ST_IDLE;
    else          state <= state_next;
  end

  // FSM next-state logic; IDLE waits for the transmitter to be fully drained.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (count != '0 && !in_Tx_Active && !in_Tx_Done) state_next = ST_LOAD;
      ST_LOAD: state_next = ST_SEND;
      ST_SEND: state_next = ST_WAIT;
      ST_WAIT: if (done_rise) state_next = (byte_idx == LAST_IDX) ? ST_IDLE : ST_SEND;
      default: state_next = ST_IDLE;
    endcase
  end

  // Frame register and byte index: load on pop, advance on each completed byte.
  always_ff @(posedge in_Clock) begin
    if (in_Reset) begin
      frame    <= 16'd0;
      byte_idx <= 2'd0;
    end else if (pop) begin
      frame    <= mem[rd_ptr];
      byte_idx <= 2'd0;
    end else if (state == ST_WAIT && done_rise && byte_idx != LAST_IDX) begin
      byte_idx <= byte_idx + 2'd1;
    end
  end

  // Output decode: the strobe and byte for the SEND cycle are prepared one
  // cycle ahead so the registered DV lines up with the SEND state.
  always_comb begin
    send_idx = (state == ST_WAIT) ? byte_idx + 2'd1 : byte_idx;
    case (send_idx)
      2'd0:    send_byte = SYNC_BYTE;
      2'd1:    send_byte = frame[15:8];
      2'd2:    send_byte = frame[7:0];
`ifdef CHECKSUM_EN
      2'd3:    send_byte = frame[15:8] ^ frame[7:0];
`endif
      default: send_byte = 8'h00;
    endcase
    tx_dv_d   = (state_next == ST_SEND);
    tx_byte_d = tx_dv_d ? send_byte : out_Tx_Byte;
  end

  // Registered transmitter outputs; the byte holds its value between strobes.
  always_ff @(posedge in_Clock) begin
    if (in_Reset) begin
      out_Tx_DV   <= 1'b0;
      out_Tx_Byte <= 8'h00;
    end else begin
      out_Tx_DV   <= tx_dv_d;
      out_Tx_Byte <= tx_byte_d;
    end
  end

endmodule

// File: tb/tb_sample_framer.sv
// Bench for sample_framer: randomized and directed sample traffic, a simple
// UART-transmitter responder, and a frame-level reference model.
`timescale 1ns/1ps
module tb_sample_framer;

  localparam int DEPTH = 4;
`ifdef CHECKSUM_EN
  localparam int NB = 4;
`else
  localparam int NB = 3;
`endif

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        rst;
  logic        valid;
  logic [15:0] sample;
  logic        ready;
  logic        dv;
  logic [7:0]  tx_byte;
  logic        active;
  logic        done;
  logic        busy;
  logic [7:0]  drop;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sample_framer #(.FIFO_DEPTH_LOG2(2), .SYNC_BYTE(8'hA5)) dut (
    .in_Clock        (clk),
    .in_Reset        (rst),
    .in_Sample_Valid (valid),
    .in_Sample       (sample),
    .out_Sample_Ready(ready),
    .out_Tx_DV       (dv),
    .out_Tx_Byte     (tx_byte),
    .in_Tx_Active    (active),
    .in_Tx_Done      (done),
    .out_Busy        (busy),
    .out_Drop_Count  (drop)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  bit checking = 0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference model.
  logic [15:0] m_fifo[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  tx_log[$];
  int          m_drop;
  bit          m_busy;
  int          m_left;
  bit          m_done_prev;
  logic [7:0]  m_last_byte;
  bit          m_full;
  bit          m_rise;
  bit          m_start;
  logic [15:0] m_s;

  // Model update: a frame starts when the framer is free, a sample is queued
  // and the transmitter is fully quiet; it ends on its NB-th Done rise.
  always @(posedge clk) begin
    if (rst) begin
      m_fifo.delete();
      exp_q.delete();
      m_drop      = 0;
      m_busy      = 0;
      m_left      = 0;
      m_done_prev = 0;
      m_last_byte = 8'h00;
    end else begin
      m_full  = (m_fifo.size() == DEPTH);
      m_rise  = done && !m_done_prev;
      m_start = !m_busy && (m_fifo.size() != 0) && !active && !done;
      if (m_busy && m_rise) begin
        m_left--;
        if (m_left == 0) m_busy = 0;
      end
      if (m_start) begin
        m_s = m_fifo.pop_front();
        exp_q.push_back(8'hA5);
        exp_q.push_back(m_s[15:8]);
        exp_q.push_back(m_s[7:0]);
        if (NB == 4) exp_q.push_back(m_s[15:8] ^ m_s[7:0]);
        m_busy = 1;
        m_left = NB;
      end
      if (valid) begin
        if (m_full) begin
          if (m_drop < 255) m_drop++;
        end else begin
          m_fifo.push_back(sample);
        end
      end
      m_done_prev = done;
    end
  end

  // Transmitter responder and per-cycle compare.
  int tx_cnt  = 0;
  int done_cnt = 0;
  logic [7:0] e_byte;

  always @(negedge clk) begin
    if (checking) begin
      if (dv) begin
        check_eq("dv_while_tx_active", {31'd0, active}, 32'd0);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_dv: got byte %0h expected no strobe at %0t", tx_byte, $time);
        end else begin
          e_byte = exp_q.pop_front();
          check_eq("tx_byte", {24'd0, tx_byte}, {24'd0, e_byte});
          m_last_byte = e_byte;
        end
      end else begin
        check_eq("tx_byte_hold", {24'd0, tx_byte}, {24'd0, m_last_byte});
      end
      check_eq("sample_ready", {31'd0, ready}, {31'd0, (m_fifo.size() != DEPTH)});
      check_eq("busy", {31'd0, busy}, {31'd0, m_busy});
      check_eq("drop_count", {24'd0, drop}, m_drop);
    end
    if (done_cnt > 0) done_cnt--;
    if (dv && !active) begin
      tx_log.push_back(tx_byte);
      active = 1'b1;
      tx_cnt = $urandom_range(8, 16);
    end else if (active) begin
      tx_cnt--;
      if (tx_cnt == 0) begin
        active   = 1'b0;
        done_cnt = 2;
      end
    end
    done = (done_cnt > 0);
  end

  // ---------------- driver tasks ----------------
  task automatic offer(input logic [15:0] s);
    valid  = 1'b1;
    sample = s;
    @(negedge clk);
    valid  = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (!(m_fifo.size() == 0 && !m_busy && !active && !done && exp_q.size() == 0) && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_timeout", {31'd0, (n >= 6000)}, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_log(input int len);
    int n = 0;
    while (tx_log.size() < len && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("wait_log_timeout", {31'd0, (n >= 2000)}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst    = 1'b1;
    valid  = 1'b0;
    sample = 16'h0000;
    active = 1'b0;
    done   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_ready", {31'd0, ready}, 32'd1);
    check_eq("reset_dv", {31'd0, dv}, 32'd0);
    check_eq("reset_byte", {24'd0, tx_byte}, 32'd0);
    check_eq("reset_busy", {31'd0, busy}, 32'd0);
    check_eq("reset_drop", {24'd0, drop}, 32'd0);
    checking = 1;
    rst = 1'b0;
    @(negedge clk);

    // Single sample: literal byte sequence pins the model.
    tx_log.delete();
    offer(16'h1234);
    wait_drain();
    check_eq("single_len", tx_log.size(), NB);
    check_eq("single_b0", {24'd0, tx_log[0]}, 32'hA5);
    check_eq("single_b1", {24'd0, tx_log[1]}, 32'h12);
    check_eq("single_b2", {24'd0, tx_log[2]}, 32'h34);
`ifdef CHECKSUM_EN
    check_eq("single_b3", {24'd0, tx_log[3]}, 32'h26);
`endif

    // Burst of 6 while the transmitter is busy with a previous frame.
    tx_log.delete();
    offer(16'h0001);
    wait_log(1);
    for (int i = 0; i < 6; i++) begin
      valid  = 1'b1;
      sample = 16'($urandom);
      @(negedge clk);
    end
    valid = 1'b0;
    check_eq("burst_drop", {24'd0, drop}, 32'd2);
    check_eq("burst_ready", {31'd0, ready}, 32'd0);
    wait_drain();
    check_eq("burst_len", tx_log.size(), 5 * NB);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      valid  = ($urandom_range(0, 3) == 0);
      sample = 16'($urandom);
      @(negedge clk);
    end
    valid = 1'b0;
    wait_drain();

    // Reset while byte 1 is in flight, then a fresh sample.
    tx_log.delete();
    offer(16'hCAFE);
    wait_log(2);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    offer(16'hBEEF);
    wait_drain();
    check_eq("rst_len", tx_log.size(), 2 + NB);
    check_eq("rst_b0", {24'd0, tx_log[0]}, 32'hA5);
    check_eq("rst_b1", {24'd0, tx_log[1]}, 32'hCA);
    check_eq("rst_new_b0", {24'd0, tx_log[2]}, 32'hA5);
    check_eq("rst_new_b1", {24'd0, tx_log[3]}, 32'hBE);
    check_eq("rst_new_b2", {24'd0, tx_log[4]}, 32'hEF);

    // Drop counter saturation.
    for (int i = 0; i < 300; i++) begin
      valid  = 1'b1;
      sample = 16'($urandom);
      @(negedge clk);
    end
    valid = 1'b0;
    check_eq("drop_saturated", {24'd0, drop}, 32'd255);
    wait_drain();
    check_eq("drop_held", {24'd0, drop}, 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
